// File: rtl/gshare_bp_unit.sv
`timescale 1ns/1ps
// ============================================================================
// gshare_bp_unit
// ----------------------------------------------------------------------------
// Gshare direction predictor for the IF stage. A table of 2-bit saturating
// counters is indexed by PC[PHT_IDX_W+1:2] XOR the global history register.
// The GHR is shifted speculatively with each predicted B-type at fetch, and it
// is repaired from the snapshot carried back by a mispredicted branch. JAL is
// always predicted taken. Saturating counters track resolved branches and
// mispredicts.
//
// Ports:
//   clk                   clock
//   rst                   asynchronous active-low reset
//   hold_flag_i           pipeline hold flag; fetch is held when >= `Hold_If
//   inst_i, inst_addr_i   fetched instruction and its PC
//   isbranch_o            predict taken / redirect
//   branch_addr_o         predicted target
//   pred_idx_o            PHT index used for this prediction
//   pred_ghr_o            GHR before this instruction's speculative update
//   resolve_valid_i       EX resolved a B-type branch this cycle
//   resolve_taken_i       actual outcome
//   resolve_mispredict_i  predicted direction was wrong
//   resolve_idx_i         pred_idx_o carried with the branch
//   resolve_ghr_i         pred_ghr_o carried with the branch
//   br_cnt_o, mis_cnt_o   resolved-branch and mispredict counters
// ============================================================================

`ifndef Hold_Flag_Bus
`define Hold_Flag_Bus 2:0
`endif
`ifndef Hold_If
`define Hold_If 3'b010
`endif
`ifndef InstBus
`define InstBus 31:0
`endif
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif

module gshare_bp_unit #(
  parameter int         GHR_W     = 4,
  parameter int         PHT_IDX_W = 6,
  parameter logic [1:0] PHT_INIT  = 2'b01,
  parameter int         CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [`Hold_Flag_Bus] hold_flag_i,
  input  logic [`InstBus]      inst_i,
  input  logic [`InstAddrBus]  inst_addr_i,
  output logic                 isbranch_o,
  output logic [`InstAddrBus]  branch_addr_o,
  output logic [PHT_IDX_W-1:0] pred_idx_o,
  output logic [GHR_W-1:0]     pred_ghr_o,
  input  logic                 resolve_valid_i,
  input  logic                 resolve_taken_i,
  input  logic                 resolve_mispredict_i,
  input  logic [PHT_IDX_W-1:0] resolve_idx_i,
  input  logic [GHR_W-1:0]     resolve_ghr_i,
  output logic [CNT_W-1:0]     br_cnt_o,
  output logic [CNT_W-1:0]     mis_cnt_o
);

  localparam int         PHT_ENTRIES = 1 << PHT_IDX_W;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]       pht [PHT_ENTRIES];
  logic [GHR_W-1:0] ghr;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_b;
  logic        is_jal;
  logic [31:0] b_imm;
  logic [31:0] j_imm;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];

  // funct3 010 and 011 are not defined for branches.
  assign is_b   = (opcode == OP_BRANCH) && (funct3 != 3'b010) && (funct3 != 3'b011);
  assign is_jal = (opcode == OP_JAL);

  assign b_imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                  inst_i[11:8], 1'b0};
  assign j_imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                  inst_i[30:21], 1'b0};

  // --------------------------------------------------------------------------
  // Prediction (combinational)
  // --------------------------------------------------------------------------
  logic [PHT_IDX_W-1:0] idx;
  logic                 pred_taken;

  // The GHR is zero-extended onto the low index bits.
  assign idx        = inst_addr_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
  // Reads the pre-update counter even if the same entry trains this cycle.
  assign pred_taken = pht[idx][1];

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    isbranch_o    = 1'b0;
    branch_addr_o = '0;
    pred_idx_o    = '0;
    pred_ghr_o    = '0;
    if (rst) begin
      pred_idx_o = idx;
      pred_ghr_o = ghr;
      if (is_b) begin
        isbranch_o    = pred_taken;
        branch_addr_o = inst_addr_i + b_imm;
      end else if (is_jal) begin
        isbranch_o    = 1'b1;
        branch_addr_o = inst_addr_i + j_imm;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Global history: repair beats the speculative shift because the fetched
  // instruction is being flushed in the same cycle.
  // --------------------------------------------------------------------------
  logic repair;
  logic spec_upd;

  assign repair   = resolve_valid_i && resolve_mispredict_i;
  assign spec_upd = is_b && (hold_flag_i < `Hold_If);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
    end else if (repair) begin
      ghr <= GHR_W'({resolve_ghr_i, resolve_taken_i});
    end else if (spec_upd) begin
      ghr <= GHR_W'({ghr, pred_taken});
    end
  end

  // --------------------------------------------------------------------------
  // PHT training
  // --------------------------------------------------------------------------
  logic [1:0] train_old;
  logic [1:0] train_new;

  assign train_old = pht[resolve_idx_i];

  always_comb begin
    train_new = train_old;
    if (resolve_taken_i) begin
      if (train_old != 2'b11) train_new = train_old + 2'b01;
    end else begin
      if (train_old != 2'b00) train_new = train_old - 2'b01;
    end
  end

  // NOTE: the PHT is deliberately reset entry by entry: the predictor must
  // start from a known weak state, so it is built from flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= PHT_INIT;
    end else if (resolve_valid_i) begin
      pht[resolve_idx_i] <= train_new;
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters (saturate at all-ones)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_o  <= '0;
      mis_cnt_o <= '0;
    end else if (resolve_valid_i) begin
      if (br_cnt_o != {CNT_W{1'b1}}) br_cnt_o <= br_cnt_o + 1'b1;
      if (resolve_mispredict_i && (mis_cnt_o != {CNT_W{1'b1}}))
        mis_cnt_o <= mis_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_gshare_bp_unit.sv
`timescale 1ns/1ps
// ============================================================================
// tb_gshare_bp_unit
// ----------------------------------------------------------------------------
// Self-checking bench for gshare_bp_unit. A behavioural model (integer PHT
// array, integer GHR, integer counters) predicts every output; a compare
// process checks the DUT on each falling edge. Directed sequences pin the
// model with hand-computed values, then randomized traffic follows. A second
// instance with 4-bit counters shares the stimulus to exercise saturation.
// ============================================================================
module tb_gshare_bp_unit;

  localparam logic [2:0] HOLD_IF = 3'b010;

  typedef enum int {K_OTHER, K_B, K_JAL} kind_e;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  hold_flag_i;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        resolve_valid_i;
  logic        resolve_taken_i;
  logic        resolve_mispredict_i;
  logic [5:0]  resolve_idx_i;
  logic [3:0]  resolve_ghr_i;

  logic        isbranch_o;
  logic [31:0] branch_addr_o;
  logic [5:0]  pred_idx_o;
  logic [3:0]  pred_ghr_o;
  logic [31:0] br_cnt_o;
  logic [31:0] mis_cnt_o;

  logic        s_isbranch;
  logic [31:0] s_branch_addr;
  logic [5:0]  s_pred_idx;
  logic [3:0]  s_pred_ghr;
  logic [3:0]  s_br_cnt;
  logic [3:0]  s_mis_cnt;

  always #5 clk = ~clk;

  gshare_bp_unit u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .hold_flag_i          (hold_flag_i),
    .inst_i               (inst_i),
    .inst_addr_i          (inst_addr_i),
    .isbranch_o           (isbranch_o),
    .branch_addr_o        (branch_addr_o),
    .pred_idx_o           (pred_idx_o),
    .pred_ghr_o           (pred_ghr_o),
    .resolve_valid_i      (resolve_valid_i),
    .resolve_taken_i      (resolve_taken_i),
    .resolve_mispredict_i (resolve_mispredict_i),
    .resolve_idx_i        (resolve_idx_i),
    .resolve_ghr_i        (resolve_ghr_i),
    .br_cnt_o             (br_cnt_o),
    .mis_cnt_o            (mis_cnt_o)
  );

  gshare_bp_unit #(.CNT_W(4)) u_small (
    .clk                  (clk),
    .rst                  (rst),
    .hold_flag_i          (hold_flag_i),
    .inst_i               (inst_i),
    .inst_addr_i          (inst_addr_i),
    .isbranch_o           (s_isbranch),
    .branch_addr_o        (s_branch_addr),
    .pred_idx_o           (s_pred_idx),
    .pred_ghr_o           (s_pred_ghr),
    .resolve_valid_i      (resolve_valid_i),
    .resolve_taken_i      (resolve_taken_i),
    .resolve_mispredict_i (resolve_mispredict_i),
    .resolve_idx_i        (resolve_idx_i),
    .resolve_ghr_i        (resolve_ghr_i),
    .br_cnt_o             (s_br_cnt),
    .mis_cnt_o            (s_mis_cnt)
  );

  // --------------------------------------------------------------------------
  // Check bookkeeping
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  kind_e       cur_kind;
  logic [31:0] cur_imm;
  int          m_pht [64];
  int          m_ghr;
  longint      m_br;
  longint      m_mis;

  function automatic int model_idx();
    return int'(((inst_addr_i >> 2) ^ 32'(m_ghr)) & 32'd63);
  endfunction

  always @(posedge clk or negedge rst) begin
    int  ix;
    int  ri;
    bit  p;
    if (!rst) begin
      for (int i = 0; i < 64; i++) m_pht[i] = 1;
      m_ghr = 0;
      m_br  = 0;
      m_mis = 0;
    end else begin
      ix = model_idx();
      p  = (m_pht[ix] >= 2);
      if (resolve_valid_i && resolve_mispredict_i)
        m_ghr = ((int'(resolve_ghr_i) * 2) + int'(resolve_taken_i)) % 16;
      else if (cur_kind == K_B && hold_flag_i < HOLD_IF)
        m_ghr = ((m_ghr * 2) + int'(p)) % 16;
      if (resolve_valid_i) begin
        ri = int'(resolve_idx_i);
        if (resolve_taken_i) m_pht[ri] = (m_pht[ri] == 3) ? 3 : m_pht[ri] + 1;
        else                 m_pht[ri] = (m_pht[ri] == 0) ? 0 : m_pht[ri] - 1;
        m_br++;
        if (resolve_mispredict_i) m_mis++;
      end
    end
  end

  // Compare process: outputs are checked every cycle, mid-period.
  always @(negedge clk) begin
    int          ix;
    logic        e_isb;
    logic [31:0] e_addr;
    if (!rst) begin
      check("rst_isbranch", 64'(isbranch_o), 0);
      check("rst_addr",     64'(branch_addr_o), 0);
      check("rst_idx",      64'(pred_idx_o), 0);
      check("rst_ghr",      64'(pred_ghr_o), 0);
      check("rst_br_cnt",   64'(br_cnt_o), 0);
      check("rst_mis_cnt",  64'(mis_cnt_o), 0);
    end else begin
      ix     = model_idx();
      e_isb  = 1'b0;
      e_addr = 32'd0;
      case (cur_kind)
        K_B:   begin e_isb = (m_pht[ix] >= 2); e_addr = inst_addr_i + cur_imm; end
        K_JAL: begin e_isb = 1'b1;             e_addr = inst_addr_i + cur_imm; end
        default: ;
      endcase
      check("isbranch",  64'(isbranch_o),    64'(e_isb));
      check("addr",      64'(branch_addr_o), 64'(e_addr));
      check("pred_idx",  64'(pred_idx_o),    64'(ix));
      check("pred_ghr",  64'(pred_ghr_o),    64'(m_ghr));
      check("br_cnt",    64'(br_cnt_o),      64'(m_br));
      check("mis_cnt",   64'(mis_cnt_o),     64'(m_mis));
      check("s_br_cnt",  64'(s_br_cnt),      64'((m_br  > 15) ? 15 : m_br));
      check("s_mis_cnt", 64'(s_mis_cnt),     64'((m_mis > 15) ? 15 : m_mis));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  task automatic set_fetch(input kind_e k, input logic [31:0] inst, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [2:0] hold);
    cur_kind    = k;
    cur_imm     = imm;
    inst_i      = inst;
    inst_addr_i = pc;
    hold_flag_i = hold;
  endtask

  task automatic fb(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] hold);
    set_fetch(K_B, enc_b(imm, 3'b000), pc, imm, hold);
  endtask

  task automatic fnop();
    set_fetch(K_OTHER, 32'h0000_0013, 32'h0, 32'h0, 3'd0);
  endtask

  task automatic resolve(input bit v, input bit t, input bit m, input int ix, input int g);
    resolve_valid_i      = v;
    resolve_taken_i      = t;
    resolve_mispredict_i = m;
    resolve_idx_i        = 6'(ix);
    resolve_ghr_i        = 4'(g);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic random_cycle();
    int          k;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] raw;
    logic [2:0]  hold;
    k    = $urandom_range(0, 3);
    pc   = $urandom & 32'hFFFF_FFFC;
    hold = 3'($urandom_range(0, 7));
    raw  = $urandom;
    case (k)
      0: begin
        if (raw[6:0] == 7'b1100011 || raw[6:0] == 7'b1101111) raw[6:0] = 7'b0110011;
        set_fetch(K_OTHER, raw, pc, 32'h0, hold);
      end
      1: begin
        imm = 32'(($urandom_range(0, 4095) - 2048) * 2);
        set_fetch(K_B, enc_b(imm, 3'($urandom_range(0, 7)) | 3'b100), pc, imm, hold);
        if ($urandom_range(0, 3) == 0) set_fetch(K_B, enc_b(imm, 3'($urandom_range(0, 1))), pc, imm, hold);
      end
      2: begin
        imm = 32'(($urandom_range(0, 1048575) - 524288) * 2);
        set_fetch(K_JAL, enc_j(imm), pc, imm, hold);
      end
      default: begin
        set_fetch(K_OTHER, enc_b(32'h10, 3'($urandom_range(2, 3))), pc, 32'h0, hold);
      end
    endcase
    resolve($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 63), $urandom_range(0, 15));
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    bit exp_train [6];
    exp_train = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset with a branch at fetch.
    fb(32'h28, 32'h10, 3'd0);
    resolve(0, 0, 0, 0, 0);
    #1;
    check("reset_isbranch", 64'(isbranch_o), 0);
    next_cycle();
    next_cycle();

    // Release; first BEQ at 0x100 predicts not-taken, idx 0.
    next_cycle();
    rst = 1'b1;
    fb(32'h100, 32'h10, 3'd0);
    #1;
    check("first_beq_isb",  64'(isbranch_o), 0);
    check("first_beq_idx",  64'(pred_idx_o), 0);
    check("first_beq_addr", 64'(branch_addr_o), 64'h110);

    // Train idx 5 up three times then down three times; fetch is held so the
    // GHR stays 0 and PC 0x14 keeps mapping to idx 5.
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      fb(32'h14, 32'h8, HOLD_IF);
      resolve(1, c < 3, 0, 5, 0);
      #1;
      check($sformatf("train_isb_%0d", c), 64'(isbranch_o), 64'(exp_train[c]));
      if (c == 0) check("train_idx", 64'(pred_idx_o), 5);
    end
    next_cycle();
    fb(32'h14, 32'h8, HOLD_IF);
    resolve(0, 0, 0, 0, 0);
    #1;
    check("train_final_isb", 64'(isbranch_o), 0);

    // Make idx 10 strongly taken.
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      fnop();
      resolve(1, 1, 0, 10, 0);
    end

    // Two taken-predicted B-types back to back: GHR 0000 -> 0001 -> 0011.
    next_cycle();
    fb(32'h28, 32'hFFFF_FFFC, 3'd0);
    resolve(0, 0, 0, 0, 0);
    #1;
    check("spec1_isb", 64'(isbranch_o), 1);
    check("spec1_ghr", 64'(pred_ghr_o), 0);
    next_cycle();
    fb(32'h2C, 32'h20, 3'd0);
    #1;
    check("spec2_idx", 64'(pred_idx_o), 10);
    check("spec2_ghr", 64'(pred_ghr_o), 1);
    check("spec2_isb", 64'(isbranch_o), 1);

    // Same fetches with hold asserted: GHR stays 0011.
    next_cycle();
    fb(32'h28, 32'hFFFF_FFFC, HOLD_IF);
    #1;
    check("ghr_0011", 64'(pred_ghr_o), 4'b0011);
    next_cycle();
    fb(32'h2C, 32'h20, HOLD_IF);
    next_cycle();
    fnop();
    #1;
    check("hold_ghr", 64'(pred_ghr_o), 4'b0011);

    // Repair beats the speculative update in the same cycle.
    next_cycle();
    fb(32'h28, 32'hFFFF_FFFC, 3'd0);
    resolve(1, 0, 1, 3, 4'b1010);

    // JAL at 0x200 with imm -8.
    next_cycle();
    set_fetch(K_JAL, enc_j(32'hFFFF_FFF8), 32'h200, 32'hFFFF_FFF8, 3'd0);
    resolve(0, 0, 0, 0, 0);
    #1;
    check("repair_ghr", 64'(pred_ghr_o), 4'b0100);
    check("jal_isb",    64'(isbranch_o), 1);
    check("jal_addr",   64'(branch_addr_o), 64'h1F8);
    next_cycle();
    fnop();
    #1;
    check("jal_ghr",     64'(pred_ghr_o), 4'b0100);
    check("dir_br_cnt",  64'(br_cnt_o), 9);
    check("dir_mis_cnt", 64'(mis_cnt_o), 1);

    // Mid-run reset with a taken-predicted branch at fetch (idx 14^4 = 10).
    next_cycle();
    fb(32'h38, 32'h14, 3'd0);
    #1;
    check("pre_rst_isb", 64'(isbranch_o), 1);
    rst = 1'b0;
    #1;
    check("mid_rst_isb",  64'(isbranch_o), 0);
    check("mid_rst_addr", 64'(branch_addr_o), 0);
    check("mid_rst_cnt",  64'(br_cnt_o), 0);
    next_cycle();
    next_cycle();
    next_cycle();
    rst = 1'b1;
    fb(32'h100, 32'h10, 3'd0);
    #1;
    check("post_rst_isb", 64'(isbranch_o), 0);
    check("post_rst_idx", 64'(pred_idx_o), 0);

    // Ten resolves, three of them mispredicts.
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      fnop();
      resolve(1, (i % 2) == 1, (i % 3) == 2, i, i);
    end
    next_cycle();
    resolve(0, 0, 0, 0, 0);
    #1;
    check("cnt_br_10",  64'(br_cnt_o), 10);
    check("cnt_mis_3",  64'(mis_cnt_o), 3);
    check("s_cnt_br_10", 64'(s_br_cnt), 10);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      next_cycle();
      random_cycle();
    end
    next_cycle();
    fnop();
    resolve(0, 0, 0, 0, 0);
    #1;
    check("s_br_sat_15", 64'(s_br_cnt), 15);

    next_cycle();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
